// File: rtl/regfile_multiport_sb.sv
// Three-read / two-write register file with a per-register load busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes (B over A) to the read ports.
module regfile_multiport_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 16,
  parameter int PC_REG     = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] wa_a,
  input  logic [DATA_WIDTH-1:0] wd_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] wa_b,
  input  logic [DATA_WIDTH-1:0] wd_b,
  input  logic                  claim_en,
  input  logic [ADDR_WIDTH-1:0] claim_addr,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  input  logic [ADDR_WIDTH-1:0] ra3,
  input  logic [DATA_WIDTH-1:0] pc_plus8,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  output logic [DATA_WIDTH-1:0] rd3,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  busy3,
  output logic [ADDR_WIDTH:0]   busy_cnt
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(PC_REG);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]      busy_cnt_q, busy_cnt_d;
  logic                  wr_a_ok, wr_b_ok, claim_ok;

  // The PC slot is never written or claimed; it only aliases pc_plus8 on reads.
  assign wr_a_ok  = we_a && (wa_a != PC_ADDR);
  assign wr_b_ok  = we_b && (wa_b != PC_ADDR);
  assign claim_ok = claim_en && (claim_addr != PC_ADDR);

  // Clear before set so a load issued in the same cycle as a retiring one stays busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_b_ok)  busy_d[wa_b]       = 1'b0;
    if (claim_ok) busy_d[claim_addr] = 1'b1;
    busy_cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (wr_a_ok) regs_q[wa_a] <= wd_a;
      // Port B is scheduled last so it wins an address collision.
      if (wr_b_ok) regs_q[wa_b] <= wd_b;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  logic [ADDR_WIDTH-1:0] ra      [3];
  logic [DATA_WIDTH-1:0] rd      [3];
  logic                  busy_rd [3];

  assign ra[0] = ra1;
  assign ra[1] = ra2;
  assign ra[2] = ra3;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd[p]      = regs_q[ra[p]];
      busy_rd[p] = busy_q[ra[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr_b_ok && (wa_b == ra[p])) begin
        rd[p]      = wd_b;
        busy_rd[p] = 1'b0;
      end else if (wr_a_ok && (wa_a == ra[p])) begin
        rd[p]      = wd_a;
      end
`endif
      if (ra[p] == PC_ADDR) begin
        rd[p]      = pc_plus8;
        busy_rd[p] = 1'b0;
      end
    end
  end

  assign rd1      = rd[0];
  assign rd2      = rd[1];
  assign rd3      = rd[2];
  assign busy1    = busy_rd[0];
  assign busy2    = busy_rd[1];
  assign busy3    = busy_rd[2];
  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Self-checking bench for regfile_multiport_sb: directed table, hand sequences, random vs model.
module tb_regfile_multiport_sb;
  localparam int DW = 32, AW = 4, NR = 16, PCR = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we_a, we_b, claim_en;
  logic [AW-1:0] wa_a, wa_b, claim_addr, ra1, ra2, ra3;
  logic [DW-1:0] wd_a, wd_b, pc_plus8;
  logic [DW-1:0] rd1, rd2, rd3;
  logic          busy1, busy2, busy3;
  logic [AW:0]   busy_cnt;

  always #5 clk = ~clk;

  regfile_multiport_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .PC_REG(PCR)) dut (
    .clk(clk), .rst_n(rst_n),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .ra1(ra1), .ra2(ra2), .ra3(ra3), .pc_plus8(pc_plus8),
    .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .busy1(busy1), .busy2(busy2), .busy3(busy3), .busy_cnt(busy_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural contents and the set of registers awaiting a load.
  logic [DW-1:0] mregs [NR];
  logic          mbusy [NR];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        mregs[i] <= '0;
        mbusy[i] <= 1'b0;
      end
    end else begin
      if (we_a && wa_a != PCR) mregs[wa_a] <= wd_a;
      if (we_b && wa_b != PCR) mregs[wa_b] <= wd_b;
      if (we_b) mbusy[wa_b] <= 1'b0;
      if (claim_en && claim_addr != PCR) mbusy[claim_addr] <= 1'b1;
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
    if (ra == PCR) return pc_plus8;
`ifdef REGFILE_BYPASS_EN
    if (we_b && wa_b == ra) return wd_b;
    if (we_a && wa_a == ra) return wd_a;
`endif
    return mregs[ra];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] ra);
    if (ra == PCR) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we_b && wa_b == ra) return 1'b0;
`endif
    return mbusy[ra];
  endfunction

  function automatic logic [DW-1:0] exp_cnt();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(mbusy[i]);
    return DW'(n);
  endfunction

  typedef struct {
    logic          we_a;  logic [AW-1:0] wa_a; logic [DW-1:0] wd_a;
    logic          we_b;  logic [AW-1:0] wa_b; logic [DW-1:0] wd_b;
    logic          cl;    logic [AW-1:0] ca;
    logic [AW-1:0] r1, r2, r3;
    logic [DW-1:0] e1, e2, e3;
    logic          eb1;
    logic [AW:0]   ecnt;
  } vec_t;

  function automatic vec_t mk(input int wea, input int waa, input int wda,
                              input int web, input int wab, input int wdb,
                              input int cl, input int ca,
                              input int r1, input int r2, input int r3,
                              input int e1, input int e2, input int e3,
                              input int eb1, input int ecnt);
    vec_t v;
    v.we_a = wea[0]; v.wa_a = AW'(waa); v.wd_a = DW'(wda);
    v.we_b = web[0]; v.wa_b = AW'(wab); v.wd_b = DW'(wdb);
    v.cl = cl[0]; v.ca = AW'(ca);
    v.r1 = AW'(r1); v.r2 = AW'(r2); v.r3 = AW'(r3);
    v.e1 = DW'(e1); v.e2 = DW'(e2); v.e3 = DW'(e3);
    v.eb1 = eb1[0]; v.ecnt = (AW+1)'(ecnt);
    return v;
  endfunction

  task automatic idle_inputs();
    we_a = 0; wa_a = '0; wd_a = '0;
    we_b = 0; wa_b = '0; wd_b = '0;
    claim_en = 0; claim_addr = '0;
  endtask

  vec_t tv [12];

  initial begin
    // Each row: one cycle of writes/claims, then reads with writes idle.
    tv[0]  = mk(1, 3, 7,     0, 0, 0,       0, 0,   3, 15, 0,   7, 16, 0,          0, 0);
    tv[1]  = mk(0, 0, 0,     1, 6, 9,       0, 0,   3, 6, 6,    7, 9, 9,           0, 0);
    tv[2]  = mk(1, 5, 8,     1, 5, 'hAA,    0, 0,   5, 6, 3,    'hAA, 9, 7,        0, 0);
    tv[3]  = mk(1, 15, 1,    0, 0, 0,       0, 0,   15, 5, 15,  16, 'hAA, 16,      0, 0);
    tv[4]  = mk(0, 0, 0,     0, 0, 0,       1, 2,   2, 2, 5,    0, 0, 'hAA,        1, 1);
    tv[5]  = mk(0, 0, 0,     1, 2, 'h55,    0, 0,   2, 3, 6,    'h55, 7, 9,        0, 0);
    tv[6]  = mk(0, 0, 0,     1, 4, 'h44,    1, 4,   4, 2, 5,    'h44, 'h55, 'hAA,  1, 1);
    tv[7]  = mk(0, 0, 0,     0, 0, 0,       1, 4,   4, 4, 4,    'h44, 'h44, 'h44,  1, 1);
    tv[8]  = mk(1, 4, 'h99,  0, 0, 0,       0, 0,   4, 3, 2,    'h99, 7, 'h55,     1, 1);
    tv[9]  = mk(0, 0, 0,     0, 0, 0,       1, 15,  15, 4, 0,   16, 'h99, 0,       0, 1);
    tv[10] = mk(0, 0, 0,     1, 4, 'h77,    0, 0,   4, 15, 5,   'h77, 16, 'hAA,    0, 0);
    tv[11] = mk(0, 0, 0,     1, 15, 'hDEAD, 0, 0,   15, 4, 6,   16, 'h77, 9,       0, 0);

    idle_inputs();
    ra1 = 4'd3; ra2 = 4'd15; ra3 = 4'd0; pc_plus8 = 32'd16;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_rd1", rd1, 0);
    chk("reset_rd2_pc", rd2, 16);
    chk("reset_busy1", DW'(busy1), 0);
    chk("reset_cnt", DW'(busy_cnt), 0);
    @(posedge clk); #1;
    chk("reset_hold_rd1", rd1, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      we_a = tv[i].we_a; wa_a = tv[i].wa_a; wd_a = tv[i].wd_a;
      we_b = tv[i].we_b; wa_b = tv[i].wa_b; wd_b = tv[i].wd_b;
      claim_en = tv[i].cl; claim_addr = tv[i].ca;
      @(posedge clk); #1;
      idle_inputs();
      ra1 = tv[i].r1; ra2 = tv[i].r2; ra3 = tv[i].r3;
      #1;
      chk($sformatf("vec%0d_rd1", i), rd1, tv[i].e1);
      chk($sformatf("vec%0d_rd2", i), rd2, tv[i].e2);
      chk($sformatf("vec%0d_rd3", i), rd3, tv[i].e3);
      chk($sformatf("vec%0d_busy1", i), DW'(busy1), DW'(tv[i].eb1));
      chk($sformatf("vec%0d_cnt", i), DW'(busy_cnt), DW'(tv[i].ecnt));
    end

    // Same-cycle write visibility on port A.
    we_a = 1; wa_a = 4'd0; wd_a = 32'd15; ra1 = 4'd0;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_a_pre", rd1, 15);
`else
    chk("bypass_a_pre", rd1, 0);
`endif
    @(posedge clk); #1;
    idle_inputs(); #1;
    chk("bypass_a_post", rd1, 15);

    // Busy clear visibility on port B.
    claim_en = 1; claim_addr = 4'd8;
    @(posedge clk); #1;
    idle_inputs(); ra1 = 4'd8; #1;
    chk("claim8_busy1", DW'(busy1), 1);
    we_b = 1; wa_b = 4'd8; wd_b = 32'h88;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_b_busy", DW'(busy1), 0);
    chk("bypass_b_rd", rd1, 32'h88);
`else
    chk("bypass_b_busy", DW'(busy1), 1);
    chk("bypass_b_rd", rd1, 0);
`endif
    @(posedge clk); #1;
    idle_inputs(); #1;
    chk("clear8_busy1", DW'(busy1), 0);
    chk("clear8_rd1", rd1, 32'h88);
    chk("clear8_cnt", DW'(busy_cnt), 0);

    // Reset arriving while a write and an outstanding load are in flight.
    we_a = 1; wa_a = 4'd7; wd_a = 32'h1111; claim_en = 1; claim_addr = 4'd9;
    @(posedge clk); #1;
    idle_inputs();
    we_a = 1; wa_a = 4'd7; wd_a = 32'h1234; ra1 = 4'd7; ra2 = 4'd9; ra3 = 4'd3;
    #1;
    chk("prereset_busy2", DW'(busy2), 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midreset_rd1", rd1, 0);
    chk("midreset_busy2", DW'(busy2), 0);
    chk("midreset_cnt", DW'(busy_cnt), 0);
    @(posedge clk); #1;
    we_a = 0;
    chk("midreset_edge_rd1", rd1, 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("postreset_rd1", rd1, 0);
    chk("postreset_rd3", rd3, 0);
    chk("postreset_busy2", DW'(busy2), 0);
    chk("postreset_cnt", DW'(busy_cnt), 0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      we_a = $urandom_range(0, 1) == 1; wa_a = AW'($urandom_range(0, 15)); wd_a = $urandom;
      we_b = $urandom_range(0, 2) == 0; wa_b = AW'($urandom_range(0, 15)); wd_b = $urandom;
      claim_en = $urandom_range(0, 2) == 0; claim_addr = AW'($urandom_range(0, 15));
      ra1 = AW'($urandom_range(0, 15)); ra2 = AW'($urandom_range(0, 15));
      ra3 = $urandom_range(0, 3) == 0 ? wa_b : AW'($urandom_range(0, 15));
      pc_plus8 = $urandom;
      #1;
      chk("rand_rd1", rd1, exp_rd(ra1));
      chk("rand_rd2", rd2, exp_rd(ra2));
      chk("rand_rd3", rd3, exp_rd(ra3));
      chk("rand_busy1", DW'(busy1), DW'(exp_busy(ra1)));
      chk("rand_busy2", DW'(busy2), DW'(exp_busy(ra2)));
      chk("rand_busy3", DW'(busy3), DW'(exp_busy(ra3)));
      @(posedge clk); #1;
      chk("rand_cnt", DW'(busy_cnt), exp_cnt());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
